axi_dma_ctrl: RTL and testbench
===============================

Name: axi_dma_ctrl

Overview:
Single-command memory-to-memory DMA engine with one AXI4 master port (AR/R/AW/W/B). It accepts a copy command (source, destination, byte length), splits it into INCR bursts, reads source data into an internal FIFO and writes it to the destination. It sits between a command producer and the system AXI interconnect.

Parameters:
ADDR_WD, 32, address and length width in bits.
DATA_WD, 32, AXI data width in bits; STRB_WD = DATA_WD/8 bytes per beat.
CHANNEL_COUNT, 8, maximum number of outstanding read bursts and outstanding write bursts.
MAX_BURST_LEN, 16, maximum beats per burst (1..256).

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
cmd_valid  in  1  command valid
cmd_src_addr  in  ADDR_WD  source byte address
cmd_dst_addr  in  ADDR_WD  destination byte address
cmd_burst  in  2  burst type; only INCR (2'b01) is supported
cmd_len  in  ADDR_WD  transfer length in bytes
cmd_size  in  3  beat size, log2 bytes; must equal log2(STRB_WD)
cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
M_AXI_ARVALID/ARREADY  out/in  1  read address handshake
M_AXI_ARADDR  out  ADDR_WD  read address
M_AXI_ARLEN  out  8  beats-1
M_AXI_ARSIZE  out  3  driven from latched cmd_size
M_AXI_ARBURST  out  2  always INCR (2'b01)
M_AXI_RVALID/RREADY  in/out  1  read data handshake
M_AXI_RDATA  in  DATA_WD  read data
M_AXI_RRESP  in  2  read response
M_AXI_RLAST  in  1  last read beat
M_AXI_AWVALID/AWREADY, M_AXI_AWADDR, M_AXI_AWLEN, M_AXI_AWSIZE, M_AXI_AWBURST: same as AR group, write side
M_AXI_WVALID/WREADY  out/in  1  write data handshake
M_AXI_WDATA  out  DATA_WD  write data
M_AXI_WSTRB  out  STRB_WD  always all ones
M_AXI_WLAST  out  1  last beat of burst
M_AXI_BVALID/BREADY  in/out  1  write response handshake
M_AXI_BRESP  in  2  write response

Behaviour:
- Reset: all VALID outputs 0, cmd_ready 0, FIFO empty, outstanding counters 0. The cycle after rst deasserts: cmd_ready=1, RREADY=1, BREADY=1.
- cmd_ready=1 only when idle: no command active, no outstanding AR/AW/B, FIFO empty. Acceptance latches src, dst, len and size, and drops cmd_ready on the next cycle.
- Addresses and len are STRB_WD-aligned; unaligned low bits are ignored (truncated). len=0 completes without any AXI traffic, and cmd_ready returns after 1 cycle.
- Burst split: beats = min(remaining beats, MAX_BURST_LEN, beats to the next 4KB boundary of the source, beats to the next 4KB boundary of the destination). Read burst i and write burst i therefore have identical lengths.
- AR issue: ARVALID is held, with stable fields, until ARREADY. A new AR is issued only if outstanding reads < CHANNEL_COUNT and the FIFO (depth 2*MAX_BURST_LEN) has free space reserved for the whole burst. Addresses and remaining count update on the handshake.
- R: every beat is pushed into the FIFO in order. RREADY stays 1; space was already reserved. The outstanding-read count decrements on the RLAST beat.
- AW issue: in burst order, as soon as outstanding writes < CHANNEL_COUNT and the AW count is below the AR count. AW is independent of data availability.
- W: beats go in AW order after that burst's AW handshake. WVALID = FIFO non-empty and the current burst is open. WLAST is asserted on the final beat of each burst. The FIFO pops on WVALID&&WREADY.
- B: BREADY=1. The outstanding-write count decrements on BVALID. The command is done when all bursts have had their B; the engine then returns to idle.
- Non-OKAY RRESP/BRESP do not stop the transfer.
- Simultaneous increment and decrement of a counter in the same cycle leaves it unchanged.
- Reset mid-operation abandons all state and returns to reset values. VALIDs drop at the reset edge.

Optional Feature:
DMA_ERR_STATUS_EN: when defined, adds output err (1 bit). err is a sticky flag set by any RRESP!=0 beat or BRESP!=0 response, and cleared by rst or by the next command acceptance. When undefined, the port is absent and responses are ignored.

Test Plan:
- src=0x100, dst=0x2000, len=64 -> one AR (0x100, ARLEN=15, ARSIZE=2, ARBURST=1); one AW (0x2000, AWLEN=15); 16 W beats equal to R data in order, WSTRB=0xF, WLAST on beat 16; cmd_ready returns after B.
- len=136 (34 beats), src=0x0, dst=0x4000 -> AR/AW bursts of 16, 16 and 2 beats at offsets 0x0, 0x40 and 0x80.
- src=0xFF8, dst=0x0, len=64 -> bursts of 2 then 14 beats: AR 0xFF8/ARLEN=1 then 0x1000/ARLEN=13; AW 0x0/AWLEN=1 then 0x8/AWLEN=13.
- 20 random aligned commands (len<256) with ARREADY/RVALID/AWREADY/WREADY throttled 1-in-5 and read latency up to 20 cycles -> destination data equals source data; outstanding reads never exceed CHANNEL_COUNT.
- len=0 -> no AXI valids; cmd_ready low for exactly 1 cycle.
- rst asserted mid-burst -> all VALIDs 0 the next cycle; cmd_ready=1 the cycle after rst deasserts; a new 64-byte command then completes correctly.

Source files
------------

// File: rtl/axi_dma_if.sv
// -----------------------------------------------------------------------------
// axi_dma_if
// Bundle of the AXI4 master signals used by axi_dma_ctrl (AR, R, AW, W, B).
//   master modport : DMA side (drives VALIDs on AR/AW/W, READYs on R/B)
//   slave  modport : memory / interconnect side
// Parameters:
//   ADDR_WD - address width in bits
//   DATA_WD - data width in bits (WSTRB is DATA_WD/8 wide)
// -----------------------------------------------------------------------------
interface axi_dma_if #(
    parameter int ADDR_WD = 32,
    parameter int DATA_WD = 32
);
    localparam int STRB_WD = DATA_WD / 8;

    logic               M_AXI_ARVALID;
    logic               M_AXI_ARREADY;
    logic [ADDR_WD-1:0] M_AXI_ARADDR;
    logic [7:0]         M_AXI_ARLEN;
    logic [2:0]         M_AXI_ARSIZE;
    logic [1:0]         M_AXI_ARBURST;

    logic               M_AXI_RVALID;
    logic               M_AXI_RREADY;
    logic [DATA_WD-1:0] M_AXI_RDATA;
    logic [1:0]         M_AXI_RRESP;
    logic               M_AXI_RLAST;

    logic               M_AXI_AWVALID;
    logic               M_AXI_AWREADY;
    logic [ADDR_WD-1:0] M_AXI_AWADDR;
    logic [7:0]         M_AXI_AWLEN;
    logic [2:0]         M_AXI_AWSIZE;
    logic [1:0]         M_AXI_AWBURST;

    logic               M_AXI_WVALID;
    logic               M_AXI_WREADY;
    logic [DATA_WD-1:0] M_AXI_WDATA;
    logic [STRB_WD-1:0] M_AXI_WSTRB;
    logic               M_AXI_WLAST;

    logic               M_AXI_BVALID;
    logic               M_AXI_BREADY;
    logic [1:0]         M_AXI_BRESP;

    modport master (
        output M_AXI_ARVALID, M_AXI_ARADDR, M_AXI_ARLEN, M_AXI_ARSIZE, M_AXI_ARBURST,
        input  M_AXI_ARREADY,
        input  M_AXI_RVALID, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RLAST,
        output M_AXI_RREADY,
        output M_AXI_AWVALID, M_AXI_AWADDR, M_AXI_AWLEN, M_AXI_AWSIZE, M_AXI_AWBURST,
        input  M_AXI_AWREADY,
        output M_AXI_WVALID, M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WLAST,
        input  M_AXI_WREADY,
        input  M_AXI_BVALID, M_AXI_BRESP,
        output M_AXI_BREADY
    );

    modport slave (
        input  M_AXI_ARVALID, M_AXI_ARADDR, M_AXI_ARLEN, M_AXI_ARSIZE, M_AXI_ARBURST,
        output M_AXI_ARREADY,
        output M_AXI_RVALID, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RLAST,
        input  M_AXI_RREADY,
        input  M_AXI_AWVALID, M_AXI_AWADDR, M_AXI_AWLEN, M_AXI_AWSIZE, M_AXI_AWBURST,
        output M_AXI_AWREADY,
        input  M_AXI_WVALID, M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WLAST,
        output M_AXI_WREADY,
        output M_AXI_BVALID, M_AXI_BRESP,
        input  M_AXI_BREADY
    );
endinterface

// File: rtl/axi_dma_ctrl.sv
// -----------------------------------------------------------------------------
// axi_dma_ctrl
// Single-command memory-to-memory DMA. A command (src, dst, byte length) is
// split into INCR bursts that never cross a 4KB page on either side; source
// data is read into an internal FIFO and written back out to the destination.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   cmd_*               - copy command (valid/ready handshake)
//   err                 - sticky response error (only with DMA_ERR_STATUS_EN)
//   m_axi               - AXI4 master port (axi_dma_if.master)
// Optional feature macro: DMA_ERR_STATUS_EN
// -----------------------------------------------------------------------------
module axi_dma_ctrl #(
    parameter int ADDR_WD       = 32,
    parameter int DATA_WD       = 32,
    parameter int CHANNEL_COUNT = 8,
    parameter int MAX_BURST_LEN = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    input  logic [ADDR_WD-1:0] cmd_src_addr,
    input  logic [ADDR_WD-1:0] cmd_dst_addr,
    input  logic [1:0]         cmd_burst,
    input  logic [ADDR_WD-1:0] cmd_len,
    input  logic [2:0]         cmd_size,
    output logic               cmd_ready,
`ifdef DMA_ERR_STATUS_EN
    output logic               err,
`endif
    axi_dma_if.master          m_axi
);
    localparam int STRB_WD = DATA_WD / 8;
    localparam int SZ      = $clog2(STRB_WD);
    localparam int DEPTH   = 2 * MAX_BURST_LEN;
    localparam int PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW      = $clog2(DEPTH + 1);
    localparam int OW      = $clog2(CHANNEL_COUNT + 1);

    localparam logic [ADDR_WD-1:0] ONE_A      = ADDR_WD'(1);
    localparam logic [ADDR_WD-1:0] MAX_A      = ADDR_WD'(MAX_BURST_LEN);
    localparam logic [ADDR_WD-1:0] PAGE_BYTES = ADDR_WD'(4096);
    localparam logic [ADDR_WD-1:0] ALIGN_MASK = ~ADDR_WD'(STRB_WD - 1);

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

    state_t             state_q;
    logic               cmd_ready_q, rready_q, bready_q;
    logic [ADDR_WD-1:0] src_q, dst_q, aw_next_q, rem_q;
    logic [2:0]         size_q;
    logic               arvalid_q, awvalid_q;
    logic [ADDR_WD-1:0] araddr_q, awaddr_q;
    logic [7:0]         arlen_q, awlen_q;
    logic [OW-1:0]      rd_out_q, wr_out_q;
    logic [CW-1:0]      pend_aw_q, pend_w_q, f_cnt_q, free_q;
    logic [7:0]         lens_q [DEPTH];
    logic [PW-1:0]      lq_wr_q, lq_aw_q, lq_w_q, f_wr_q, f_rd_q;
    logic [DATA_WD-1:0] fifo_q [DEPTH];
    logic [7:0]         w_beat_q;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? {PW{1'b0}} : p + PW'(1);
    endfunction

    // Burst length: limited by remaining beats, max burst and both 4KB pages.
    logic [ADDR_WD-1:0] src_room_s, dst_room_s, beats_a_s, beats_b_s, beats_s;
    assign src_room_s = (PAGE_BYTES - ADDR_WD'(src_q[11:0])) >> SZ;
    assign dst_room_s = (PAGE_BYTES - ADDR_WD'(dst_q[11:0])) >> SZ;
    assign beats_a_s  = (rem_q < MAX_A) ? rem_q : MAX_A;
    assign beats_b_s  = (src_room_s < beats_a_s) ? src_room_s : beats_a_s;
    assign beats_s    = (dst_room_s < beats_b_s) ? dst_room_s : beats_b_s;

    logic ar_hs_s, r_hs_s, rlast_hs_s, aw_hs_s, wvalid_s, w_hs_s, wlast_s, b_hs_s;
    logic ar_go_s, aw_go_s, done_s;
    assign ar_hs_s    = arvalid_q && m_axi.M_AXI_ARREADY;
    assign r_hs_s     = m_axi.M_AXI_RVALID && rready_q;
    assign rlast_hs_s = r_hs_s && m_axi.M_AXI_RLAST;
    assign aw_hs_s    = awvalid_q && m_axi.M_AXI_AWREADY;
    assign wvalid_s   = (f_cnt_q != {CW{1'b0}}) && (pend_w_q != {CW{1'b0}});
    assign w_hs_s     = wvalid_s && m_axi.M_AXI_WREADY;
    assign wlast_s    = (w_beat_q == lens_q[lq_w_q]);
    assign b_hs_s     = m_axi.M_AXI_BVALID && bready_q;

    // A read is launched only with FIFO space reserved for the whole burst,
    // so R beats can always be accepted.
    assign ar_go_s = (state_q == ST_RUN) && !arvalid_q && (rem_q != {ADDR_WD{1'b0}}) &&
                     (rd_out_q < OW'(CHANNEL_COUNT)) && (ADDR_WD'(free_q) >= beats_s);
    assign aw_go_s = (state_q == ST_RUN) && !awvalid_q && (pend_aw_q != {CW{1'b0}}) &&
                     (wr_out_q < OW'(CHANNEL_COUNT));
    assign done_s  = (state_q == ST_RUN) && (rem_q == {ADDR_WD{1'b0}}) && !arvalid_q &&
                     !awvalid_q && (rd_out_q == {OW{1'b0}}) && (wr_out_q == {OW{1'b0}}) &&
                     (pend_aw_q == {CW{1'b0}}) && (pend_w_q == {CW{1'b0}}) &&
                     (f_cnt_q == {CW{1'b0}});

    // Command FSM, burst issue, outstanding counters and data FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cmd_ready_q <= 1'b0;
            rready_q    <= 1'b0;
            bready_q    <= 1'b0;
            src_q       <= {ADDR_WD{1'b0}};
            dst_q       <= {ADDR_WD{1'b0}};
            aw_next_q   <= {ADDR_WD{1'b0}};
            rem_q       <= {ADDR_WD{1'b0}};
            size_q      <= 3'd0;
            arvalid_q   <= 1'b0;
            awvalid_q   <= 1'b0;
            araddr_q    <= {ADDR_WD{1'b0}};
            awaddr_q    <= {ADDR_WD{1'b0}};
            arlen_q     <= 8'd0;
            awlen_q     <= 8'd0;
            rd_out_q    <= {OW{1'b0}};
            wr_out_q    <= {OW{1'b0}};
            pend_aw_q   <= {CW{1'b0}};
            pend_w_q    <= {CW{1'b0}};
            f_cnt_q     <= {CW{1'b0}};
            free_q      <= CW'(DEPTH);
            lq_wr_q     <= {PW{1'b0}};
            lq_aw_q     <= {PW{1'b0}};
            lq_w_q      <= {PW{1'b0}};
            f_wr_q      <= {PW{1'b0}};
            f_rd_q      <= {PW{1'b0}};
            w_beat_q    <= 8'd0;
        end else begin
            rready_q <= 1'b1;
            bready_q <= 1'b1;

            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid && cmd_ready_q) begin
                        state_q     <= ST_RUN;
                        cmd_ready_q <= 1'b0;
                        src_q       <= cmd_src_addr & ALIGN_MASK;
                        dst_q       <= cmd_dst_addr & ALIGN_MASK;
                        aw_next_q   <= cmd_dst_addr & ALIGN_MASK;
                        rem_q       <= cmd_len >> SZ;
                        size_q      <= cmd_size;
                    end else begin
                        cmd_ready_q <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (done_s) begin
                        state_q     <= ST_IDLE;
                        cmd_ready_q <= 1'b1;
                    end else begin
                        cmd_ready_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    cmd_ready_q <= 1'b0;
                end
            endcase

            // AR channel: fields latched at launch, pointers advance at handshake.
            if (ar_go_s) begin
                arvalid_q        <= 1'b1;
                araddr_q         <= src_q;
                arlen_q          <= 8'(beats_s - ONE_A);
                lens_q[lq_wr_q]  <= 8'(beats_s - ONE_A);
                lq_wr_q          <= ptr_inc(lq_wr_q);
            end else if (ar_hs_s) begin
                arvalid_q <= 1'b0;
                src_q     <= src_q + ((ADDR_WD'(arlen_q) + ONE_A) << SZ);
                dst_q     <= dst_q + ((ADDR_WD'(arlen_q) + ONE_A) << SZ);
                rem_q     <= rem_q - (ADDR_WD'(arlen_q) + ONE_A);
            end else begin
                arvalid_q <= arvalid_q;
            end

            // AW channel: follows AR bursts in order, using the recorded lengths.
            if (aw_go_s) begin
                awvalid_q <= 1'b1;
                awaddr_q  <= aw_next_q;
                awlen_q   <= lens_q[lq_aw_q];
                aw_next_q <= aw_next_q + ((ADDR_WD'(lens_q[lq_aw_q]) + ONE_A) << SZ);
                lq_aw_q   <= ptr_inc(lq_aw_q);
            end else if (aw_hs_s) begin
                awvalid_q <= 1'b0;
            end else begin
                awvalid_q <= awvalid_q;
            end

            // W beat counter; the length entry is retired on the last beat.
            if (w_hs_s) begin
                if (wlast_s) begin
                    w_beat_q <= 8'd0;
                    lq_w_q   <= ptr_inc(lq_w_q);
                end else begin
                    w_beat_q <= w_beat_q + 8'd1;
                end
            end else begin
                w_beat_q <= w_beat_q;
            end

            if (r_hs_s) begin
                fifo_q[f_wr_q] <= m_axi.M_AXI_RDATA;
                f_wr_q         <= ptr_inc(f_wr_q);
            end else begin
                f_wr_q <= f_wr_q;
            end
            if (w_hs_s) begin
                f_rd_q <= ptr_inc(f_rd_q);
            end else begin
                f_rd_q <= f_rd_q;
            end

            f_cnt_q   <= f_cnt_q + CW'(r_hs_s) - CW'(w_hs_s);
            free_q    <= free_q - (ar_go_s ? CW'(beats_s) : {CW{1'b0}}) + CW'(w_hs_s);
            rd_out_q  <= rd_out_q + OW'(ar_hs_s) - OW'(rlast_hs_s);
            wr_out_q  <= wr_out_q + OW'(aw_hs_s) - OW'(b_hs_s);
            pend_aw_q <= pend_aw_q + CW'(ar_hs_s) - CW'(aw_go_s);
            pend_w_q  <= pend_w_q + CW'(aw_hs_s) - CW'(w_hs_s && wlast_s);
        end
    end

`ifdef DMA_ERR_STATUS_EN
    logic err_q;
    // Sticky error flag, cleared when the next command is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (cmd_valid && cmd_ready_q && (state_q == ST_IDLE)) begin
            err_q <= 1'b0;
        end else if ((r_hs_s && (m_axi.M_AXI_RRESP != 2'b00)) ||
                     (b_hs_s && (m_axi.M_AXI_BRESP != 2'b00))) begin
            err_q <= 1'b1;
        end else begin
            err_q <= err_q;
        end
    end
    assign err = err_q;
`endif

    // Only INCR is supported and responses are not acted on.
    logic unused_s;
    assign unused_s = ^{cmd_burst, m_axi.M_AXI_RRESP, m_axi.M_AXI_BRESP};

    assign cmd_ready             = cmd_ready_q;
    assign m_axi.M_AXI_ARVALID   = arvalid_q;
    assign m_axi.M_AXI_ARADDR    = araddr_q;
    assign m_axi.M_AXI_ARLEN     = arlen_q;
    assign m_axi.M_AXI_ARSIZE    = size_q;
    assign m_axi.M_AXI_ARBURST   = 2'b01;
    assign m_axi.M_AXI_RREADY    = rready_q;
    assign m_axi.M_AXI_AWVALID   = awvalid_q;
    assign m_axi.M_AXI_AWADDR    = awaddr_q;
    assign m_axi.M_AXI_AWLEN     = awlen_q;
    assign m_axi.M_AXI_AWSIZE    = size_q;
    assign m_axi.M_AXI_AWBURST   = 2'b01;
    assign m_axi.M_AXI_WVALID    = wvalid_s;
    assign m_axi.M_AXI_WDATA     = fifo_q[f_rd_q];
    assign m_axi.M_AXI_WSTRB     = {STRB_WD{1'b1}};
    assign m_axi.M_AXI_WLAST     = wlast_s;
    assign m_axi.M_AXI_BREADY    = bready_q;
endmodule

// File: tb/tb_axi_dma_ctrl.sv
// -----------------------------------------------------------------------------
// tb_axi_dma_ctrl
// Directed bench for axi_dma_ctrl with a behavioural AXI memory: reads return
// pat(word address), writes land in dst_mem. Optional ready throttling.
// -----------------------------------------------------------------------------
module tb_axi_dma_ctrl;
    localparam int AWD = 32;
    localparam int DWD = 32;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
    } axreq_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic [31:0] cmd_src_addr, cmd_dst_addr, cmd_len;
    logic [1:0]  cmd_burst;
    logic [2:0]  cmd_size;
    logic        cmd_ready;
`ifdef DMA_ERR_STATUS_EN
    logic        err;
`endif

    axi_dma_if #(.ADDR_WD(AWD), .DATA_WD(DWD)) bus ();

    axi_dma_ctrl #(.ADDR_WD(AWD), .DATA_WD(DWD), .CHANNEL_COUNT(8), .MAX_BURST_LEN(16)) dut (
        .clk(clk),
        .rst(rst),
        .cmd_valid(cmd_valid),
        .cmd_src_addr(cmd_src_addr),
        .cmd_dst_addr(cmd_dst_addr),
        .cmd_burst(cmd_burst),
        .cmd_len(cmd_len),
        .cmd_size(cmd_size),
        .cmd_ready(cmd_ready),
`ifdef DMA_ERR_STATUS_EN
        .err(err),
`endif
        .m_axi(bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit throttle = 1'b0;

    logic [31:0] dst_mem [0:16383];
    axreq_t ar_log[$], aw_log[$], ar_pend[$], aw_pend[$];
    int rd_out = 0, rd_out_max = 0, valid_cycles = 0;
    int w_err = 0, w_beats = 0, b_pend = 0, b_count = 0;
    bit rv = 1'b0, r_busy = 1'b0, bv = 1'b0, w_busy = 1'b0;
    logic [31:0] r_addr = 32'h0, w_addr = 32'h0;
    int r_left = 0, r_delay = 0, w_left = 0;

    function automatic logic [31:0] pat(input logic [31:0] w);
        return (w * 32'h0100_0193) ^ 32'hA5A5_5A5A;
    endfunction

    function automatic bit go();
        return !throttle || ($urandom_range(0, 4) != 0);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Read side of the memory model.
    always @(posedge clk) begin
        axreq_t req;
        if (rst) begin
            rv = 1'b0; r_busy = 1'b0; rd_out = 0;
            ar_pend.delete();
            bus.M_AXI_ARREADY <= 1'b0;
            bus.M_AXI_RVALID  <= 1'b0;
            bus.M_AXI_RLAST   <= 1'b0;
            bus.M_AXI_RDATA   <= 32'h0;
            bus.M_AXI_RRESP   <= 2'b00;
        end else begin
            if (bus.M_AXI_ARVALID && bus.M_AXI_ARREADY) begin
                req = '{addr: bus.M_AXI_ARADDR, len: bus.M_AXI_ARLEN,
                        size: bus.M_AXI_ARSIZE, burst: bus.M_AXI_ARBURST};
                ar_pend.push_back(req);
                ar_log.push_back(req);
                rd_out++;
                if (rd_out > rd_out_max) rd_out_max = rd_out;
            end
            if (rv && bus.M_AXI_RREADY) begin
                if (r_left == 1) begin
                    r_busy = 1'b0;
                    rd_out--;
                end
                r_left--;
                r_addr += 32'd4;
                rv = 1'b0;
            end
            if (!r_busy && ar_pend.size() != 0) begin
                req = ar_pend.pop_front();
                r_busy = 1'b1;
                r_addr = req.addr;
                r_left = int'(req.len) + 1;
                r_delay = throttle ? int'($urandom_range(0, 20)) : 0;
            end
            if (r_busy && !rv) begin
                if (r_delay > 0) r_delay--;
                else if (go()) rv = 1'b1;
            end
            bus.M_AXI_ARREADY <= go();
            bus.M_AXI_RVALID  <= rv;
            bus.M_AXI_RDATA   <= pat(r_addr >> 2);
            bus.M_AXI_RLAST   <= (r_left == 1);
            bus.M_AXI_RRESP   <= 2'b00;
        end
    end

    // Write side of the memory model; protocol slips are counted in w_err.
    always @(posedge clk) begin
        axreq_t req;
        if (rst) begin
            bv = 1'b0; w_busy = 1'b0; b_pend = 0;
            aw_pend.delete();
            bus.M_AXI_AWREADY <= 1'b0;
            bus.M_AXI_WREADY  <= 1'b0;
            bus.M_AXI_BVALID  <= 1'b0;
            bus.M_AXI_BRESP   <= 2'b00;
        end else begin
            if (bus.M_AXI_AWVALID && bus.M_AXI_AWREADY) begin
                req = '{addr: bus.M_AXI_AWADDR, len: bus.M_AXI_AWLEN,
                        size: bus.M_AXI_AWSIZE, burst: bus.M_AXI_AWBURST};
                aw_pend.push_back(req);
                aw_log.push_back(req);
            end
            if (bus.M_AXI_WVALID && bus.M_AXI_WREADY) begin
                w_beats++;
                if (!w_busy && aw_pend.size() != 0) begin
                    req = aw_pend.pop_front();
                    w_busy = 1'b1;
                    w_addr = req.addr;
                    w_left = int'(req.len) + 1;
                end
                if (!w_busy) w_err++;
                else begin
                    if (bus.M_AXI_WSTRB != 4'hF) w_err++;
                    if (bus.M_AXI_WLAST != (w_left == 1)) w_err++;
                    dst_mem[w_addr[15:2]] = bus.M_AXI_WDATA;
                    w_addr += 32'd4;
                    w_left--;
                    if (w_left == 0) begin
                        w_busy = 1'b0;
                        b_pend++;
                    end
                end
            end
            if (bv && bus.M_AXI_BREADY) begin
                bv = 1'b0;
                b_count++;
            end
            if (!bv && b_pend > 0 && go()) begin
                bv = 1'b1;
                b_pend--;
            end
            bus.M_AXI_AWREADY <= go();
            bus.M_AXI_WREADY  <= go();
            bus.M_AXI_BVALID  <= bv;
            bus.M_AXI_BRESP   <= 2'b00;
        end
    end

    // Counts cycles with any master VALID high.
    always @(posedge clk) begin
        if (!rst && (bus.M_AXI_ARVALID || bus.M_AXI_AWVALID || bus.M_AXI_WVALID))
            valid_cycles++;
    end

    task automatic issue_cmd(input logic [31:0] src, input logic [31:0] dst, input logic [31:0] len);
        int n = 0;
        while (cmd_ready !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("ready_before_cmd", 64'(cmd_ready), 64'd1);
        @(negedge clk);
        cmd_valid    = 1'b1;
        cmd_src_addr = src;
        cmd_dst_addr = dst;
        cmd_len      = len;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (cmd_ready !== 1'b1 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("cmd_done_timeout", 64'(n < 5000), 64'd1);
    endtask

    task automatic check_copy(input logic [31:0] src, input logic [31:0] dst, input int nwords);
        for (int i = 0; i < nwords; i++) begin
            logic [31:0] di;
            di = (dst >> 2) + 32'(i);
            chk("copy_data", 64'(dst_mem[di[13:0]]), 64'(pat((src >> 2) + 32'(i))));
        end
    endtask

    initial begin
        int a0, w0, b0, v0, wb0, n;
        logic [31:0] exp_addr [3];
        logic [7:0]  exp_len [3];
        logic [31:0] s, d, l;

        rst = 1'b1; cmd_valid = 1'b0; cmd_src_addr = 32'h0; cmd_dst_addr = 32'h0;
        cmd_len = 32'h0; cmd_burst = 2'b01; cmd_size = 3'd2;
        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
        chk("rst_arvalid", 64'(bus.M_AXI_ARVALID), 64'd0);
        chk("rst_awvalid", 64'(bus.M_AXI_AWVALID), 64'd0);
        chk("rst_wvalid", 64'(bus.M_AXI_WVALID), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("post_rst_rready", 64'(bus.M_AXI_RREADY), 64'd1);
        chk("post_rst_bready", 64'(bus.M_AXI_BREADY), 64'd1);

        // Single 16-beat burst.
        a0 = ar_log.size(); w0 = aw_log.size(); b0 = b_count; wb0 = w_beats;
        issue_cmd(32'h100, 32'h2000, 32'd64);
        wait_idle();
        chk("t1_ar_count", 64'(ar_log.size() - a0), 64'd1);
        chk("t1_araddr", 64'(ar_log[a0].addr), 64'h100);
        chk("t1_arlen", 64'(ar_log[a0].len), 64'd15);
        chk("t1_arsize", 64'(ar_log[a0].size), 64'd2);
        chk("t1_arburst", 64'(ar_log[a0].burst), 64'd1);
        chk("t1_aw_count", 64'(aw_log.size() - w0), 64'd1);
        chk("t1_awaddr", 64'(aw_log[w0].addr), 64'h2000);
        chk("t1_awlen", 64'(aw_log[w0].len), 64'd15);
        chk("t1_awsize", 64'(aw_log[w0].size), 64'd2);
        chk("t1_w_beats", 64'(w_beats - wb0), 64'd16);
        chk("t1_b_count", 64'(b_count - b0), 64'd1);
        check_copy(32'h100, 32'h2000, 16);

        // 34 beats -> 16 + 16 + 2.
        a0 = ar_log.size(); w0 = aw_log.size();
        issue_cmd(32'h0, 32'h4000, 32'd136);
        wait_idle();
        exp_addr = '{32'h0, 32'h40, 32'h80};
        exp_len  = '{8'd15, 8'd15, 8'd1};
        chk("t2_ar_count", 64'(ar_log.size() - a0), 64'd3);
        chk("t2_aw_count", 64'(aw_log.size() - w0), 64'd3);
        for (int i = 0; i < 3; i++) begin
            if (ar_log.size() > a0 + i && aw_log.size() > w0 + i) begin
                chk("t2_araddr", 64'(ar_log[a0 + i].addr), 64'(exp_addr[i]));
                chk("t2_arlen", 64'(ar_log[a0 + i].len), 64'(exp_len[i]));
                chk("t2_awaddr", 64'(aw_log[w0 + i].addr), 64'(32'h4000 + exp_addr[i]));
                chk("t2_awlen", 64'(aw_log[w0 + i].len), 64'(exp_len[i]));
            end
        end
        check_copy(32'h0, 32'h4000, 34);

        // Source crosses a 4KB page: 2 beats then 14.
        a0 = ar_log.size(); w0 = aw_log.size();
        issue_cmd(32'hFF8, 32'h0, 32'd64);
        wait_idle();
        chk("t3_ar_count", 64'(ar_log.size() - a0), 64'd2);
        chk("t3_aw_count", 64'(aw_log.size() - w0), 64'd2);
        if (ar_log.size() >= a0 + 2 && aw_log.size() >= w0 + 2) begin
            chk("t3_araddr0", 64'(ar_log[a0].addr), 64'hFF8);
            chk("t3_arlen0", 64'(ar_log[a0].len), 64'd1);
            chk("t3_araddr1", 64'(ar_log[a0 + 1].addr), 64'h1000);
            chk("t3_arlen1", 64'(ar_log[a0 + 1].len), 64'd13);
            chk("t3_awaddr0", 64'(aw_log[w0].addr), 64'h0);
            chk("t3_awlen0", 64'(aw_log[w0].len), 64'd1);
            chk("t3_awaddr1", 64'(aw_log[w0 + 1].addr), 64'h8);
            chk("t3_awlen1", 64'(aw_log[w0 + 1].len), 64'd13);
        end
        check_copy(32'hFF8, 32'h0, 16);

        // Zero length: no traffic, cmd_ready low for one cycle.
        a0 = ar_log.size(); v0 = valid_cycles;
        issue_cmd(32'h200, 32'h600, 32'd0);
        chk("t4_ready_low", 64'(cmd_ready), 64'd0);
        @(posedge clk);
        #1;
        chk("t4_ready_back", 64'(cmd_ready), 64'd1);
        repeat (3) @(negedge clk);
        chk("t4_no_valids", 64'(valid_cycles - v0), 64'd0);
        chk("t4_no_ar", 64'(ar_log.size() - a0), 64'd0);

        // Reset in the middle of a transfer.
        wb0 = w_beats;
        issue_cmd(32'h300, 32'h3000, 32'd64);
        n = 0;
        while (w_beats == wb0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("t5_w_started", 64'(n < 500), 64'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("t5_arvalid", 64'(bus.M_AXI_ARVALID), 64'd0);
        chk("t5_awvalid", 64'(bus.M_AXI_AWVALID), 64'd0);
        chk("t5_wvalid", 64'(bus.M_AXI_WVALID), 64'd0);
        chk("t5_cmd_ready", 64'(cmd_ready), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("t5_ready_after_rst", 64'(cmd_ready), 64'd1);
        a0 = ar_log.size();
        issue_cmd(32'h500, 32'h3000, 32'd64);
        wait_idle();
        chk("t5_ar_count", 64'(ar_log.size() - a0), 64'd1);
        check_copy(32'h500, 32'h3000, 16);

        // Throttled commands at assorted alignments and lengths.
        throttle = 1'b1;
        for (int k = 0; k < 20; k++) begin
            s = 32'($urandom_range(0, 32'h1FFF)) << 2;
            d = 32'h8000 + (32'($urandom_range(0, 32'h1F00)) << 2);
            l = 32'($urandom_range(0, 63)) << 2;
            issue_cmd(s, d, l);
            wait_idle();
            check_copy(s, d, int'(l >> 2));
        end
        throttle = 1'b0;
        chk("max_outstanding_reads", 64'(rd_out_max <= 8), 64'd1);
        chk("w_protocol_errors", 64'(w_err), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
